regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the single-cycle MIPS datapath and its planned pipelined successor. Generalises the 32x32 two-read/one-write file to configurable width, depth and read-port count, and adds a second write port, same-cycle write-to-read bypass and a per-register pending scoreboard. Long-latency producers, such as a multi-cycle load or multiply unit, use the scoreboard to mark their destination busy so decode can stall on it.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers
- NREAD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 hard-wired to zero and never pending
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

- Clock  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- WrEn0  in  1  write port 0 enable
- WrAddr0  in  ADDR_W  write port 0 address
- WrData0  in  DATA_W  write port 0 data
- WrEn1  in  1  write port 1 enable (priority port)
- WrAddr1  in  ADDR_W  write port 1 address
- WrData1  in  DATA_W  write port 1 data
- SetPend  in  1  mark SetPendAddr pending at next edge
- SetPendAddr  in  ADDR_W  register claimed by a long-latency producer
- ReadAddr  in  NREAD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- ReadData  out  NREAD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W]
- ReadPend  out  NREAD  1 = port i addresses a register whose value is not yet valid
- PendAny  out  1  OR of all pending bits (registered state only)

## Operation
- Storage: 2**ADDR_W x DATA_W registers plus 2**ADDR_W pending bits.
- Reset (Reset_n low, asynchronous): all registers = 0, all pending = 0. While low, ReadData = 0, ReadPend = 0, PendAny = 0; writes and SetPend are ignored.
- Write: at a rising edge, each port with WrEnX = 1 updates reg[WrAddrX].
  - If ZERO_REG = 1, a write to address 0 is discarded.
  - If both ports target the same address, port 1's data is stored.
- Pending set/clear: at a rising edge, an enabled write clears pend[WrAddrX]. SetPend = 1 sets pend[SetPendAddr].
  - If set and clear target the same address in the same cycle, set wins, because a new producer has issued.
  - If ZERO_REG = 1, SetPend to address 0 is ignored.
- Read, per port i (combinational):
  - If ZERO_REG = 1 and the address is 0: ReadData = 0, ReadPend = 0.
  - Else if BYPASS = 1 and an enabled write port matches the address: ReadData = that port's WrData (port 1 over port 0), ReadPend = 0.
  - Otherwise: ReadData = reg[addr], ReadPend = pend[addr].
- With BYPASS = 0, reads never see in-flight write data, and ReadPend reflects registered pend only.
- PendAny is derived from the registered pending bits only; it does not reflect same-cycle bypass.

## Timing
- Write latency: 1 edge. Data is visible via storage from the cycle after the edge; with BYPASS = 1 it is also visible in the same cycle.
- Read latency: 0 cycles, combinational from ReadAddr, write ports and state.
- Pending latency: SetPend in cycle n gives ReadPend = 1 from cycle n+1. The clearing write in cycle m gives ReadPend = 0 in cycle m with BYPASS = 1, or cycle m+1 with BYPASS = 0.
- Reset assertion takes effect immediately, with no clock required. Release is synchronised externally; the first write is accepted at the first edge after Reset_n goes high.
- Reset mid-operation: any in-flight pending state is lost, and every register reads 0 after release.
- No combinational path from ReadAddr to any state element.

## Test plan
- Reset: preload reg5 = 0xDEADBEEF and pend7, then pulse Reset_n low between edges → ReadData for reg5 = 0 immediately, PendAny = 0, reg5 still 0 after release.
- Zero register: WrEn0 = 1, WrAddr0 = 0, WrData0 = 0x1234, plus SetPend to addr 0 → reading addr 0 gives 0 and ReadPend = 0, both same cycle and next cycle.
- Dual-write collision: in one cycle, WrAddr0 = WrAddr1 = 9 with WrData0 = 0xAAAA0000 and WrData1 = 0x5555FFFF → in the same cycle (bypass) and afterwards, addr 9 reads 0x5555FFFF on every read port.
- Bypass: write 0x00000042 to reg3 while read port 1 addresses 3 → port 1 shows 0x42 in that cycle. Repeat with BYPASS = 0 → the old value shows in that cycle and 0x42 from the next cycle.
- Scoreboard: SetPend on reg12 in cycle 0 → ReadPend = 1 and PendAny = 1 from cycle 1. Write reg12 = 0x77 in cycle 4 → ReadPend = 0 in cycle 4 and PendAny = 0 from cycle 5.
- Set/clear race: reg12 pending, then in one cycle WrEn1 writes reg12 = 0x99 and SetPend targets 12 → reg12 = 0x99 stored, pend12 = 1 afterwards, PendAny stays 1.

Source files
------------

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write, scoreboard and read bundle for regfile_mp.
// master = datapath/decode side, slave = register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
);

  logic                    WrEn0;
  logic [ADDR_W-1:0]       WrAddr0;
  logic [DATA_W-1:0]       WrData0;
  logic                    WrEn1;
  logic [ADDR_W-1:0]       WrAddr1;
  logic [DATA_W-1:0]       WrData1;
  logic                    SetPend;
  logic [ADDR_W-1:0]       SetPendAddr;
  logic [NREAD*ADDR_W-1:0] ReadAddr;
  logic [NREAD*DATA_W-1:0] ReadData;
  logic [NREAD-1:0]        ReadPend;
  logic                    PendAny;

  modport master (
    output WrEn0,
    output WrAddr0,
    output WrData0,
    output WrEn1,
    output WrAddr1,
    output WrData1,
    output SetPend,
    output SetPendAddr,
    output ReadAddr,
    input  ReadData,
    input  ReadPend,
    input  PendAny
  );

  modport slave (
    input  WrEn0,
    input  WrAddr0,
    input  WrData0,
    input  WrEn1,
    input  WrAddr1,
    input  WrData1,
    input  SetPend,
    input  SetPendAddr,
    input  ReadAddr,
    output ReadData,
    output ReadPend,
    output PendAny
  );

endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: 2**ADDR_W x DATA_W register file, two write ports,
// NREAD combinational read ports, write bypass and pending scoreboard.
// Ports: Clock, Reset_n (async, active-low), bus (regfile_mp_if.slave):
//   WrEn/WrAddr/WrData 0,1 (port 1 has priority), SetPend/SetPendAddr,
//   ReadAddr -> ReadData/ReadPend per port, PendAny = OR of pend state.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         Clock,
  input  logic         Reset_n,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;

  logic wr0_v;
  logic wr1_v;
  logic set_v;

  // Writes and claims aimed at a hard-wired zero register are dropped.
  assign wr0_v = bus.WrEn0 &
                 ~(ZR & (bus.WrAddr0 == '0));
  assign wr1_v = bus.WrEn1 &
                 ~(ZR & (bus.WrAddr1 == '0));
  assign set_v = bus.SetPend &
                 ~(ZR & (bus.SetPendAddr == '0));

  // Port 1 is applied after port 0 so it wins a collision;
  // the set is applied last so a fresh producer outlives a clear.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr0_v) begin
      regs_d[bus.WrAddr0] = bus.WrData0;
      pend_d[bus.WrAddr0] = 1'b0;
    end
    if (wr1_v) begin
      regs_d[bus.WrAddr1] = bus.WrData1;
      pend_d[bus.WrAddr1] = 1'b0;
    end
    if (set_v) begin
      pend_d[bus.SetPendAddr] = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= '0;
      end
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rp;

    assign ra = bus.ReadAddr[i*ADDR_W +: ADDR_W];

    // Outputs are forced low while in reset so that a bypassed
    // write cannot leak through before the file is usable.
    always_comb begin
      rd = regs_q[ra];
      rp = pend_q[ra];
      if (ZR && (ra == '0)) begin
        rd = '0;
        rp = 1'b0;
      end else if (BP && wr1_v && (bus.WrAddr1 == ra)) begin
        rd = bus.WrData1;
        rp = 1'b0;
      end else if (BP && wr0_v && (bus.WrAddr0 == ra)) begin
        rd = bus.WrData0;
        rp = 1'b0;
      end
      if (!Reset_n) begin
        rd = '0;
        rp = 1'b0;
      end
    end

    assign bus.ReadData[i*DATA_W +: DATA_W] = rd;
    assign bus.ReadPend[i] = rp;
  end

  assign bus.PendAny = Reset_n & (|pend_q);

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vectors against a BYPASS=1 and a BYPASS=0
// instance, with a queued-expectation scoreboard drained by a monitor.
module tb_regfile_mp;

  logic Clock = 1'b0;
  logic Reset_n;

  always #5 Clock = ~Clock;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) f0 ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) f1 ();

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NREAD(2),
    .ZERO_REG(1), .BYPASS(1)
  ) u_bp (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .bus    (f0)
  );

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NREAD(2),
    .ZERO_REG(1), .BYPASS(0)
  ) u_nb (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .bus    (f1)
  );

  typedef struct {
    bit          inst;
    int          port;
    logic [31:0] d;
    logic        p;
    logic        a;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  event chk_ev;

  task automatic drive(
    input logic        we0,
    input logic [4:0]  a0,
    input logic [31:0] d0,
    input logic        we1,
    input logic [4:0]  a1,
    input logic [31:0] d1,
    input logic        sp,
    input logic [4:0]  spa,
    input logic [4:0]  r0,
    input logic [4:0]  r1
  );
    f0.WrEn0 = we0; f0.WrAddr0 = a0; f0.WrData0 = d0;
    f0.WrEn1 = we1; f0.WrAddr1 = a1; f0.WrData1 = d1;
    f0.SetPend = sp; f0.SetPendAddr = spa;
    f0.ReadAddr = {r1, r0};
    f1.WrEn0 = we0; f1.WrAddr0 = a0; f1.WrData0 = d0;
    f1.WrEn1 = we1; f1.WrAddr1 = a1; f1.WrData1 = d1;
    f1.SetPend = sp; f1.SetPendAddr = spa;
    f1.ReadAddr = {r1, r0};
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  task automatic ex(
    input bit          inst,
    input int          port,
    input logic [31:0] d,
    input logic        p,
    input logic        a,
    input string       nm
  );
    exp_t e;
    e.inst = inst; e.port = port;
    e.d = d; e.p = p; e.a = a; e.nm = nm;
    q.push_back(e);
  endtask

  // same expectation on both instances
  task automatic ex2(
    input int          port,
    input logic [31:0] d,
    input logic        p,
    input logic        a,
    input string       nm
  );
    ex(1'b0, port, d, p, a, nm);
    ex(1'b1, port, d, p, a, nm);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Monitor: drains the queue whenever outputs are settled
  // (falling edge, or an explicit strobe during reset).
  initial begin : monitor
    exp_t        e;
    logic [63:0] rd;
    logic [1:0]  rp;
    logic        pa;
    logic [31:0] ad;
    forever begin
      @(negedge Clock or chk_ev);
      while (q.size() > 0) begin
        e  = q.pop_front();
        rd = e.inst ? f1.ReadData : f0.ReadData;
        rp = e.inst ? f1.ReadPend : f0.ReadPend;
        pa = e.inst ? f1.PendAny  : f0.PendAny;
        ad = rd[e.port*32 +: 32];
        n_chk++;
        if (ad === e.d && rp[e.port] === e.p && pa === e.a) begin
          n_pass++;
        end else begin
          $display("FAIL %s inst%0d port%0d: got d=%h p=%b any=%b want d=%h p=%b any=%b",
                   e.nm, e.inst, e.port, ad, rp[e.port], pa,
                   e.d, e.p, e.a);
        end
      end
    end
  end

  initial begin : stim
    Reset_n = 1'b0;
    idle(0, 0);
    step();
    step();
    ex2(0, 32'h0, 0, 0, "reset_state");
    ex2(1, 32'h0, 0, 0, "reset_state");
    Reset_n = 1'b1;
    step();

    // preload reg5, claim reg7
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 7, 5, 7);
    ex(0, 0, 32'hDEADBEEF, 0, 0, "preload_bypass");
    ex(1, 0, 32'h0, 0, 0, "preload_nobypass");
    ex2(1, 32'h0, 0, 0, "pend7_not_yet");
    step();
    idle(5, 7);
    ex2(0, 32'hDEADBEEF, 0, 1, "reg5_stored");
    ex2(1, 32'h0, 1, 1, "pend7_set");
    @(negedge Clock);
    #1;
    Reset_n = 1'b0;
    #1;
    ex2(0, 32'h0, 0, 0, "async_reset_reg5");
    ex2(1, 32'h0, 0, 0, "async_reset_pend7");
    ->chk_ev;
    #1;
    Reset_n = 1'b1;
    step();
    idle(5, 7);
    ex2(0, 32'h0, 0, 0, "reg5_after_release");
    ex2(1, 32'h0, 0, 0, "pend7_after_release");
    step();

    // zero register
    drive(1, 0, 32'h1234, 0, 0, 0, 1, 0, 0, 0);
    ex2(0, 32'h0, 0, 0, "zero_same");
    ex2(1, 32'h0, 0, 0, "zero_same");
    step();
    idle(0, 0);
    ex2(0, 32'h0, 0, 0, "zero_next");
    ex2(1, 32'h0, 0, 0, "zero_next");
    step();

    // dual-write collision on reg9
    drive(1, 9, 32'hAAAA0000, 1, 9, 32'h5555FFFF, 0, 0, 9, 9);
    ex(0, 0, 32'h5555FFFF, 0, 0, "collide_bypass");
    ex(0, 1, 32'h5555FFFF, 0, 0, "collide_bypass");
    ex(1, 0, 32'h0, 0, 0, "collide_nobypass");
    ex(1, 1, 32'h0, 0, 0, "collide_nobypass");
    step();
    idle(9, 9);
    ex2(0, 32'h5555FFFF, 0, 0, "collide_stored");
    ex2(1, 32'h5555FFFF, 0, 0, "collide_stored");
    step();

    // bypass on read port 1
    drive(1, 3, 32'h11, 0, 0, 0, 0, 0, 0, 3);
    step();
    drive(1, 3, 32'h42, 0, 0, 0, 0, 0, 0, 3);
    ex(0, 1, 32'h42, 0, 0, "bypass_same");
    ex(1, 1, 32'h11, 0, 0, "nobypass_old");
    step();
    idle(0, 3);
    ex2(1, 32'h42, 0, 0, "bypass_next");
    step();

    // scoreboard on reg12
    drive(0, 0, 0, 0, 0, 0, 1, 12, 12, 12);
    ex2(0, 32'h0, 0, 0, "sb_cycle0");
    step();
    idle(12, 12);
    ex2(0, 32'h0, 1, 1, "sb_cycle1");
    step();
    idle(12, 12);
    ex2(1, 32'h0, 1, 1, "sb_cycle2");
    step();
    idle(12, 12);
    step();
    drive(0, 0, 0, 1, 12, 32'h77, 0, 0, 12, 12);
    ex(0, 0, 32'h77, 0, 1, "sb_clear_bypass");
    ex(1, 0, 32'h0, 1, 1, "sb_clear_nobypass");
    step();
    idle(12, 12);
    ex2(0, 32'h77, 0, 0, "sb_cycle5");
    step();

    // set/clear race on reg12
    drive(0, 0, 0, 0, 0, 0, 1, 12, 12, 12);
    step();
    drive(0, 0, 0, 1, 12, 32'h99, 1, 12, 12, 12);
    ex(0, 0, 32'h99, 0, 1, "race_bypass");
    ex(1, 0, 32'h77, 1, 1, "race_nobypass");
    step();
    idle(12, 12);
    ex2(0, 32'h99, 1, 1, "race_after");
    ex2(1, 32'h99, 1, 1, "race_after");
    step();

    // independent writes on both ports
    drive(1, 20, 32'hA0, 1, 21, 32'hB1, 0, 0, 20, 21);
    ex(0, 0, 32'hA0, 0, 1, "dual_bypass0");
    ex(0, 1, 32'hB1, 0, 1, "dual_bypass1");
    step();
    idle(20, 21);
    ex2(0, 32'hA0, 0, 1, "dual_stored0");
    ex2(1, 32'hB1, 0, 1, "dual_stored1");
    step();

    @(negedge Clock);
    #1;
    if (q.size() != 0) begin
      $display("FAIL drain: %0d expectations left unchecked", q.size());
      n_chk += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
